// File: rtl/target_display.sv
// Seven-segment front panel for the brute-force driver: scans the current
// 32-bit candidate as 8 hex digits, puts status flags on the decimal points,
// and freezes the candidate on a hit (blinking) or on exhaustion (steady).
module target_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] target,
  input  logic        status_paused,
  input  logic        status_running,
  input  logic        status_warming,
  input  logic        status_found,
  input  logic        status_done,
  output logic [7:0]  SEG,
  output logic [7:0]  DIGIT,
  output logic        held
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {LIVE, HELD_FOUND, HELD_DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          shown_q, shown_d;
  logic [2:0]           idx_q, idx_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic                 found_q, found_d;
  logic [7:0]           seg_q, seg_d;
  logic [7:0]           digit_q, digit_d;
  logic                 held_q, held_d;
  logic                 found_rise;
  logic                 blank;
  logic [3:0]           nibble;
  logic                 flag;

  // Active-low g..a glyphs for one hex nibble
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // Digit scan timer; runs in every state
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
  end

  // Freeze/blink state machine; blink state is zero outside HELD_FOUND
  always_comb begin
    state_d       = state_q;
    shown_d       = shown_q;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    found_d       = status_found;
    found_rise    = status_found & ~found_q;
    case (state_q)
      LIVE: begin
        shown_d = target;
        if (found_rise)       state_d = HELD_FOUND;
        else if (status_done) state_d = HELD_DONE;
      end
      HELD_FOUND: begin
        if (!status_found) begin
          state_d = LIVE;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
          blink_phase_d = blink_phase_q;
        end
      end
      HELD_DONE: begin
        if (found_rise)        state_d = HELD_FOUND;
        else if (!status_done) state_d = LIVE;
      end
      default: state_d = LIVE;
    endcase
    held_d = (state_d != LIVE);
  end

  // Segment/anode image for the digit currently selected
  always_comb begin
    blank  = (state_q == HELD_FOUND) & blink_phase_q;
    nibble = shown_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      3'd0:    flag = status_found;
      3'd1:    flag = status_done;
      3'd2:    flag = status_warming;
      3'd3:    flag = status_running;
      3'd4:    flag = status_paused;
      default: flag = 1'b0;
    endcase
    seg_d   = {~flag, hex_glyph(nibble)};
    digit_d = ~(8'd1 << idx_q);
    if (blank) begin
      seg_d   = 8'hFF;
      digit_d = 8'hFF;
    end
  end

  // All state and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= LIVE;
      shown_q       <= '0;
      idx_q         <= '0;
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      found_q       <= 1'b0;
      seg_q         <= 8'hFF;
      digit_q       <= 8'hFF;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shown_q       <= shown_d;
      idx_q         <= idx_d;
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      found_q       <= found_d;
      seg_q         <= seg_d;
      digit_q       <= digit_d;
      held_q        <= held_d;
    end
  end

  assign SEG   = seg_q;
  assign DIGIT = digit_q;
  assign held  = held_q;

endmodule

// File: tb/tb_target_display.sv
// Directed bench for target_display with SCAN_DIV=4, BLINK_DIV=16.
module tb_target_display;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] target;
  logic        status_paused, status_running, status_warming;
  logic        status_found, status_done;
  logic [7:0]  SEG, DIGIT;
  logic        held;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  target_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .CLK(CLK), .RESET(RESET), .target(target),
    .status_paused(status_paused), .status_running(status_running),
    .status_warming(status_warming), .status_found(status_found),
    .status_done(status_done), .SEG(SEG), .DIGIT(DIGIT), .held(held)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  // fl = {paused, running, warming, done, found}
  function automatic logic [7:0] eseg(input logic [31:0] s, input int i,
                                      input logic [4:0] fl, input bit blnk);
    logic [31:0] sh;
    logic        dp;
    sh = s >> (4 * i);
    dp = (i < 5) ? ~fl[i] : 1'b1;
    eseg = blnk ? 8'hFF : {dp, glyph(sh[3:0])};
  endfunction

  function automatic logic [7:0] edig(input int i, input bit blnk);
    logic [7:0] one;
    one  = 8'd1;
    edig = blnk ? 8'hFF : ~(one << i);
  endfunction

  function automatic int cur_idx();
    cur_idx = ((cyc - 1) >> 2) & 7;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [31:0] s,
                          input logic [4:0] fl, input bit blnk);
    chk({tag, "_seg"}, 32'(SEG), 32'(eseg(s, cur_idx(), fl, blnk)));
    chk({tag, "_dig"}, 32'(DIGIT), 32'(edig(cur_idx(), blnk)));
  endtask

  initial begin
    RESET = 1'b1; target = '0;
    status_paused = 0; status_running = 0; status_warming = 0;
    status_found = 0; status_done = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_seg", 32'(SEG), 32'hFF);
    chk("rst_dig", 32'(DIGIT), 32'hFF);
    chk("rst_held", 32'(held), 32'h0);

    // Plain scan of a live candidate
    target = 32'h0123ABCD; RESET = 1'b0; cyc = 0;
    step();
    chk("first_seg", 32'(SEG), 32'hC0);
    chk("first_dig", 32'(DIGIT), 32'hFE);
    step(); step();
    chk_disp("scan0", 32'h0123ABCD, 5'b0, 1'b0);
    for (int d = 1; d <= 8; d++) begin
      repeat (4) step();
      chk_disp("scan", 32'h0123ABCD, 5'b0, 1'b0);
    end

    // Running + paused decimal points
    status_running = 1; status_paused = 1;
    for (int d = 1; d <= 8; d++) begin
      repeat (4) step();
      chk_disp("dp", 32'h0123ABCD, 5'b11000, 1'b0);
    end
    status_running = 0; status_paused = 0;

    // Hit while target counts up: freeze on DEADBEEF and blink
    target = 32'hDEADBEEE;
    step();
    target = 32'hDEADBEEF; status_found = 1;
    step();
    chk("found_held", 32'(held), 32'h1);
    for (int k = 2; k <= 40; k++) begin
      target = target + 32'd1;
      step();
      chk("blink_held", 32'(held), 32'h1);
      chk_disp("blink", 32'hDEADBEEF, 5'b00001, (((k - 2) / 16) % 2) == 1);
    end

    // Release of found: back to live tracking
    status_found = 0; target = 32'h89ABCDEF;
    step();
    chk("unfound_held", 32'(held), 32'h0);
    step();
    chk_disp("unfound_frozen", 32'hDEADBEEF, 5'b0, 1'b0);
    step();
    chk_disp("unfound_live", 32'h89ABCDEF, 5'b0, 1'b0);

    // Found and done together: found wins
    status_found = 1; status_done = 1;
    step();
    chk("both_held", 32'(held), 32'h1);
    repeat (17) step();
    chk("both_blank_seg", 32'(SEG), 32'hFF);
    chk("both_blank_dig", 32'(DIGIT), 32'hFF);

    // Drop found with done high: LIVE one cycle, then HELD_DONE steady
    status_found = 0; target = 32'h13579BDF;
    step();
    chk("drop_live_held", 32'(held), 32'h0);
    step();
    chk("done_held", 32'(held), 32'h1);
    target = 32'h0;
    repeat (18) step();
    chk_disp("done_a", 32'h13579BDF, 5'b00010, 1'b0);
    repeat (12) step();
    chk_disp("done_b", 32'h13579BDF, 5'b00010, 1'b0);
    chk("done_held2", 32'(held), 32'h1);

    // Found rise from HELD_DONE, then async reset while held
    status_found = 1;
    step();
    chk("hd2hf_held", 32'(held), 32'h1);
    repeat (5) step();
    RESET = 1'b1;
    #1;
    chk("arst_seg", 32'(SEG), 32'hFF);
    chk("arst_dig", 32'(DIGIT), 32'hFF);
    chk("arst_held", 32'(held), 32'h0);
    status_done = 0;
    @(posedge CLK);
    #1;
    RESET = 1'b0; cyc = 0; target = 32'hFFFFFFFF;
    step();
    chk("post_held", 32'(held), 32'h1);
    chk("post_seg", 32'(SEG), 32'h40);
    chk("post_dig", 32'(DIGIT), 32'hFE);
    repeat (4) step();
    chk_disp("post_scan", 32'hFFFFFFFF, 5'b00001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
